count_capture: RTL

Timestamp-capture stage that sits directly downstream of the user-area `counter`. It consumes the free-running `count` value and snapshots it into a small FIFO whenever a selected edge occurs on one user I/O pad. The management SoC reads captured timestamps over its own Wishbone slave window and can take an interrupt while the FIFO is non-empty or has overflowed.

---
 rtl/count_capture_pkg.sv | 40 ++++
 rtl/capture_fifo.sv | 60 ++++++
 rtl/count_capture.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/count_capture_pkg.sv
// Shared definitions for the timestamp-capture block: register map,
// CTRL/STATUS bit positions and the edge-select encoding.
package count_capture_pkg;

   // Register offsets, decoded from adr[3:2]
   typedef enum logic [1:0] {
      CTRL   = 2'd0,
      STATUS = 2'd1,
      DATA   = 2'd2,
      LAST   = 2'd3
   } reg_addr_e;

   // CTRL bit positions
   localparam int CTRL_EN       = 0;
   localparam int CTRL_EDGE_LSB = 1;
   localparam int CTRL_IRQ_EN   = 3;
   localparam int CTRL_FLUSH    = 4;

   // STATUS bit positions
   localparam int STAT_LEVEL_LSB = 0;
   localparam int STAT_LEVEL_W   = 5;
   localparam int STAT_EMPTY     = 8;
   localparam int STAT_FULL      = 9;
   localparam int STAT_OVF       = 10;

   // Which pad edges generate a capture
   typedef enum logic [1:0] {
      EDGE_NONE = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_BOTH = 2'b11
   } edge_e;

   // True when the detected edge matches the selected edge mode
   function automatic logic edge_hit(input edge_e sel, input logic rise, input logic fall);
      return (((sel == EDGE_RISE) || (sel == EDGE_BOTH)) & rise) |
             (((sel == EDGE_FALL) || (sel == EDGE_BOTH)) & fall);
   endfunction

endpackage

// File: rtl/capture_fifo.sv
// Small timestamp FIFO. Pointers carry one extra wrap bit so full and
// empty are distinguished without a separate counter. The head entry is
// presented combinationally; the parent registers it on read.
module capture_fifo #(
   parameter int BITS  = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [BITS-1:0]            din,
   output logic [BITS-1:0]            dout,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       full,
   output logic                       empty,
   output logic                       drop
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]     wr_ptr_reg;
   logic [AW:0]     rd_ptr_reg;
   logic [BITS-1:0] mem [DEPTH];
   logic            pop_ok;
   logic            push_ok;

   assign level = wr_ptr_reg - rd_ptr_reg;
   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &
                  (wr_ptr_reg[AW] != rd_ptr_reg[AW]);

   // A pop on an empty FIFO is ignored; a push into a full FIFO only
   // lands if a real pop frees the slot in the same cycle. Flush wins.
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & ~flush & (~full | pop_ok);
   assign drop    = push & ~flush & full & ~pop_ok;
   assign dout    = mem[rd_ptr_reg[AW-1:0]];

   // Pointer update: flush resets both so level reads 0 next cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

   // Storage write; contents need no reset since pointers gate visibility
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= din;
   end

endmodule

// File: rtl/count_capture.sv
// Timestamp capture: synchronizes a pad, detects the selected edge,
// snapshots count_i into a FIFO and exposes it over a Wishbone slave.
module count_capture
   import count_capture_pkg::*;
#(
   parameter int BITS  = 32,
   parameter int DEPTH = 4
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic            wbs_stb_i,
   input  logic            wbs_cyc_i,
   input  logic            wbs_we_i,
   input  logic [3:0]      wbs_sel_i,
   input  logic [31:0]     wbs_dat_i,
   input  logic [31:0]     wbs_adr_i,
   output logic            wbs_ack_o,
   output logic [31:0]     wbs_dat_o,
   input  logic [BITS-1:0] count_i,
   input  logic            cap_in,
   output logic            irq_o
);

   localparam int LW = $clog2(DEPTH) + 1;

   logic            s1_reg, s2_reg, s3_reg;
   logic            rise, fall, cap_event;
   logic            ctrl_en_reg;
   edge_e           edge_sel_reg;
   logic            irq_en_reg;
   logic            ovf_reg;
   logic [BITS-1:0] last_reg;
   logic            ack_reg;
   logic [31:0]     dat_reg;
   logic            irq_reg;

   reg_addr_e       reg_adr;
   logic            access, wr_access, rd_access;
   logic            ctrl_wr, flush, ovf_clr, pop;
   logic [31:0]     rdata;

   logic [BITS-1:0] fifo_dout;
   logic [LW-1:0]   fifo_level;
   logic            fifo_full, fifo_empty, fifo_drop;

   logic            unused_bits;

   assign unused_bits = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:11],
                          wbs_dat_i[9:5], wbs_sel_i[3:2]};

   // Pad synchronizer plus history flop; runs even when capture is off
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         s1_reg <= 1'b0;
         s2_reg <= 1'b0;
         s3_reg <= 1'b0;
      end else begin
         s1_reg <= cap_in;
         s2_reg <= s1_reg;
         s3_reg <= s2_reg;
      end
   end

   assign rise      = s2_reg & ~s3_reg;
   assign fall      = ~s2_reg & s3_reg;
   assign cap_event = ctrl_en_reg & edge_hit(edge_sel_reg, rise, fall);

   // Bus decode: one access per request, taken on the edge that raises ack
   assign reg_adr   = reg_addr_e'(wbs_adr_i[3:2]);
   assign access    = wbs_cyc_i & wbs_stb_i & ~ack_reg;
   assign wr_access = access & wbs_we_i;
   assign rd_access = access & ~wbs_we_i;
   assign ctrl_wr   = wr_access & (reg_adr == CTRL) & wbs_sel_i[0];
   assign flush     = ctrl_wr & wbs_dat_i[CTRL_FLUSH];
   assign ovf_clr   = wr_access & (reg_adr == STATUS) & wbs_sel_i[1] & wbs_dat_i[STAT_OVF];
   assign pop       = rd_access & (reg_adr == DATA);

   capture_fifo #(
      .BITS  (BITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (wb_clk_i),
      .rst   (wb_rst_i),
      .push  (cap_event),
      .pop   (pop),
      .flush (flush),
      .din   (count_i),
      .dout  (fifo_dout),
      .level (fifo_level),
      .full  (fifo_full),
      .empty (fifo_empty),
      .drop  (fifo_drop)
   );

   // Read mux; DATA returns 0 rather than stale storage when empty
   always_comb begin
      rdata = '0;
      case (reg_adr)
         CTRL: begin
            rdata[CTRL_EN]               = ctrl_en_reg;
            rdata[CTRL_EDGE_LSB +: 2]    = edge_sel_reg;
            rdata[CTRL_IRQ_EN]           = irq_en_reg;
         end
         STATUS: begin
            rdata[STAT_LEVEL_LSB +: STAT_LEVEL_W] = STAT_LEVEL_W'(fifo_level);
            rdata[STAT_EMPTY] = fifo_empty;
            rdata[STAT_FULL]  = fifo_full;
            rdata[STAT_OVF]   = ovf_reg;
         end
         DATA: begin
            if (!fifo_empty) rdata = 32'(fifo_dout);
         end
         LAST: begin
            rdata = 32'(last_reg);
         end
         default: rdata = '0;
      endcase
   end

   // Control register, sticky overflow, last-capture copy
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         ctrl_en_reg  <= 1'b0;
         edge_sel_reg <= EDGE_NONE;
         irq_en_reg   <= 1'b0;
         ovf_reg      <= 1'b0;
         last_reg     <= '0;
      end else begin
         if (ctrl_wr) begin
            ctrl_en_reg  <= wbs_dat_i[CTRL_EN];
            edge_sel_reg <= edge_e'(wbs_dat_i[CTRL_EDGE_LSB +: 2]);
            irq_en_reg   <= wbs_dat_i[CTRL_IRQ_EN];
         end
         if (fifo_drop)    ovf_reg <= 1'b1;
         else if (ovf_clr) ovf_reg <= 1'b0;
         if (cap_event) last_reg <= count_i;
      end
   end

   // Wishbone handshake: single-cycle ack with registered read data
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         ack_reg <= 1'b0;
         dat_reg <= '0;
      end else begin
         ack_reg <= access;
         if (access) dat_reg <= rdata;
      end
   end

   // Level interrupt while data is pending or an overflow is flagged
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) irq_reg <= 1'b0;
      else          irq_reg <= irq_en_reg & (~fifo_empty | ovf_reg);
   end

   assign wbs_ack_o = ack_reg;
   assign wbs_dat_o = dat_reg;
   assign irq_o     = irq_reg;

endmodule
